// File: rtl/npu_isa_pkg.sv
// NPU instruction-set definitions shared by the dispatcher and the assembler model.
// Field positions, opcodes and the decoded-instruction record live here so both agree on one encoding.
package npu_isa_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_EU    = 2'b11
    } op_t;

    localparam logic [4:0] SYNC_GROUP = 5'h1F;

    localparam int OP_LSB         = 30;
    localparam int EXEC_BIT       = 29;
    localparam int GROUP_LSB      = 24;
    localparam int LDST_RF_LSB    = 21;
    localparam int LDST_SDRAM_LSB = 8;
    localparam int MOVE_SRC_LSB   = 20;
    localparam int MOVE_DST_LSB   = 10;
    localparam int SRC_FRZ_BIT    = 9;
    localparam int DST_FRZ_BIT    = 8;
    localparam int SUB_IDX_LSB    = 20;

    typedef struct packed {
        op_t         op;
        logic        exec;
        logic [4:0]  group;
        logic        is_sync;
        logic        illegal;
        logic [8:0]  ldst_rf;
        logic [12:0] ldst_sdram;
        logic [9:0]  move_src;
        logic [9:0]  move_dst;
        logic        src_frz;
        logic        dst_frz;
        logic [7:0]  line_num;
        logic [3:0]  sub_idx;
        logic [23:0] fetch;
    } dec_t;

    // Group 0x1F is only meaningful as SYNC (exec=1); any other use of it traps.
    function automatic dec_t decode_inst(input logic [31:0] w, input int n_groups);
        dec_t d;
        d.op         = op_t'(w[OP_LSB +: 2]);
        d.exec       = w[EXEC_BIT];
        d.group      = w[GROUP_LSB +: 5];
        d.is_sync    = (d.op == OP_EU) && (d.group == SYNC_GROUP) && d.exec;
        d.illegal    = (d.op == OP_EU) && !d.is_sync &&
                       ((d.group == SYNC_GROUP) || (int'(d.group) >= n_groups));
        d.ldst_rf    = w[LDST_RF_LSB +: 9];
        d.ldst_sdram = w[LDST_SDRAM_LSB +: 13];
        d.move_src   = w[MOVE_SRC_LSB +: 10];
        d.move_dst   = w[MOVE_DST_LSB +: 10];
        d.src_frz    = w[SRC_FRZ_BIT];
        d.dst_frz    = w[DST_FRZ_BIT];
        d.line_num   = w[7:0];
        d.sub_idx    = w[SUB_IDX_LSB +: 4];
        d.fetch      = w[23:0];
        return d;
    endfunction

endpackage

// File: rtl/inst_dispatch_if.sv
// Instruction stream in, LDST / mover / EU-group commands out, busy status back.
// master = the dispatcher, slave = fetcher plus execution units.
interface inst_dispatch_if #(
    parameter int RF_ADDR_W = 10,
    parameter int N_GROUPS  = 8
);
    logic                 inst_valid;
    logic [31:0]          inst;
    logic                 inst_ready;

    logic                 ldst_valid;
    logic                 ldst_ready;
    logic                 ldst_store;
    logic [RF_ADDR_W-1:0] ldst_rf_addr;
    logic [31:0]          ldst_sdram_addr;
    logic [7:0]           ldst_line_num;

    logic                 move_valid;
    logic                 move_ready;
    logic [RF_ADDR_W-1:0] move_src_addr;
    logic [RF_ADDR_W-1:0] move_dst_addr;
    logic                 move_src_freeze;
    logic                 move_dst_freeze;
    logic [7:0]           move_line_num;

    logic [N_GROUPS-1:0]  eu_valid;
    logic [N_GROUPS-1:0]  eu_ready;
    logic                 eu_exec;
    logic [3:0]           eu_sub_idx;
    logic [31:0]          eu_fetch_addr;

    logic                 ldst_busy;
    logic                 move_busy;
    logic [N_GROUPS-1:0]  eu_busy;

    logic                 sync_active;
    logic                 err_illegal;
    logic [31:0]          issued_cnt;

    modport master (
        input  inst_valid, inst, ldst_ready, move_ready, eu_ready,
               ldst_busy, move_busy, eu_busy,
        output inst_ready,
               ldst_valid, ldst_store, ldst_rf_addr, ldst_sdram_addr, ldst_line_num,
               move_valid, move_src_addr, move_dst_addr, move_src_freeze,
               move_dst_freeze, move_line_num,
               eu_valid, eu_exec, eu_sub_idx, eu_fetch_addr,
               sync_active, err_illegal, issued_cnt
    );

    modport slave (
        output inst_valid, inst, ldst_ready, move_ready, eu_ready,
               ldst_busy, move_busy, eu_busy,
        input  inst_ready,
               ldst_valid, ldst_store, ldst_rf_addr, ldst_sdram_addr, ldst_line_num,
               move_valid, move_src_addr, move_dst_addr, move_src_freeze,
               move_dst_freeze, move_line_num,
               eu_valid, eu_exec, eu_sub_idx, eu_fetch_addr,
               sync_active, err_illegal, issued_cnt
    );
endinterface

// File: rtl/inst_dispatch_fifo.sv
// Synchronous FIFO for the instruction queue, registered storage, head visible combinationally.
// Latency: a push at edge N is at the head after edge N; push is ignored while full.
// Backpressure: full blocks the writer; pop only acts when not empty.
module inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             push, pop;

    assign push    = push_vld && !full;
    assign pop     = pop_rdy && pop_vld;
    // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_vld = (wptr != rptr);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/inst_dispatch.sv
// In-order NPU instruction dispatcher: FIFO -> registered issue slot -> LDST / mover / EU group.
// Latency: push at edge N, command valid after edge N+1; back-to-back issue at 1 instr/cycle.
// Backpressure: valid holds until ready; inst_ready = queue not full; SYNC stalls until all units idle.
module inst_dispatch
    import npu_isa_pkg::*;
#(
    parameter int          RF_ADDR_W    = 10,
    parameter logic [14:0] SDRAM_OFFSET = 15'h1000,
    parameter int          N_GROUPS     = 8,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_dispatch_if.master io
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_SYNC_WAIT = 2'd2;

    logic [1:0]          state;
    dec_t                slot, head;
    logic [31:0]         fifo_dat;
    logic                fifo_vld, fifo_full;
    logic                pop, load, done, cmd_rdy, all_idle, issuing;
    logic [N_GROUPS-1:0] eu_sel;

    inst_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (io.inst_valid),
        .push_dat (io.inst),
        .full     (fifo_full),
        .pop_rdy  (pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat)
    );

    assign io.inst_ready = !fifo_full;
    assign head          = decode_inst(fifo_dat, N_GROUPS);
    assign eu_sel        = N_GROUPS'(1) << slot.group;
    assign issuing       = (state == ST_ISSUE) && !slot.is_sync && !slot.illegal;
    assign all_idle      = !io.ldst_busy && !io.move_busy && !(|io.eu_busy);

    always_comb begin
        cmd_rdy = 1'b0;
        case (slot.op)
            OP_LOAD, OP_STORE: cmd_rdy = io.ldst_ready;
            OP_MOVE:           cmd_rdy = io.move_ready;
            default:           cmd_rdy = |(io.eu_ready & eu_sel);
        endcase
    end

    // Slot frees when it is empty or its occupant retires this cycle; illegal heads are
    // popped and discarded without ever occupying the slot.
    assign done = (issuing && cmd_rdy) || ((state == ST_SYNC_WAIT) && all_idle);
    assign pop  = fifo_vld && ((state == ST_IDLE) || done);
    assign load = pop && !head.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            slot           <= '0;
            io.err_illegal <= 1'b0;
            io.issued_cnt  <= '0;
        end else begin
            if (load) begin
                slot  <= head;
                state <= head.is_sync ? ST_SYNC_WAIT : ST_ISSUE;
            end else if (done) begin
                state <= ST_IDLE;
            end
            if (pop && head.illegal) io.err_illegal <= 1'b1;
            if (done)                io.issued_cnt  <= io.issued_cnt + 32'd1;
        end
    end

    assign io.sync_active     = (state == ST_SYNC_WAIT);

    assign io.ldst_valid      = issuing && ((slot.op == OP_LOAD) || (slot.op == OP_STORE));
    assign io.ldst_store      = (slot.op == OP_STORE);
    assign io.ldst_rf_addr    = RF_ADDR_W'(slot.ldst_rf);
    assign io.ldst_sdram_addr = {SDRAM_OFFSET, slot.ldst_sdram, 4'b0};
    assign io.ldst_line_num   = slot.line_num;

    assign io.move_valid      = issuing && (slot.op == OP_MOVE);
    assign io.move_src_addr   = RF_ADDR_W'(slot.move_src);
    assign io.move_dst_addr   = RF_ADDR_W'(slot.move_dst);
    assign io.move_src_freeze = slot.src_frz;
    assign io.move_dst_freeze = slot.dst_frz;
    assign io.move_line_num   = slot.line_num;

    assign io.eu_valid        = (issuing && (slot.op == OP_EU)) ? eu_sel : '0;
    assign io.eu_exec         = slot.exec;
    assign io.eu_sub_idx      = slot.sub_idx;
    assign io.eu_fetch_addr   = {4'b0, slot.fetch, 4'b0};
endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch; a negedge monitor pops expected commands from per-channel queues.
module tb_inst_dispatch;

    typedef struct {
        logic        store;
        logic [9:0]  rf;
        logic [31:0] addr;
        logic [7:0]  line;
    } ldst_exp_t;

    typedef struct {
        logic [9:0] src;
        logic [9:0] dst;
        logic       sf;
        logic       df;
        logic [7:0] line;
    } move_exp_t;

    typedef struct {
        logic [7:0]  vld;
        logic        exec;
        logic [3:0]  sub;
        logic [31:0] addr;
    } eu_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    ldst_exp_t ldst_q[$];
    move_exp_t move_q[$];
    eu_exp_t   eu_q[$];

    always #5 clk = ~clk;

    inst_dispatch_if #(.RF_ADDR_W(10), .N_GROUPS(8)) io ();

    inst_dispatch #(
        .RF_ADDR_W    (10),
        .SDRAM_OFFSET (15'h1000),
        .N_GROUPS     (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (io.ldst_valid && io.ldst_ready) begin
                chk("ldst_expected", 64'(ldst_q.size() != 0), 1);
                if (ldst_q.size() != 0) begin
                    ldst_exp_t e;
                    e = ldst_q.pop_front();
                    chk("ldst_store", io.ldst_store, e.store);
                    chk("ldst_rf_addr", io.ldst_rf_addr, e.rf);
                    chk("ldst_sdram_addr", io.ldst_sdram_addr, e.addr);
                    chk("ldst_line_num", io.ldst_line_num, e.line);
                end
            end
            if (io.move_valid && io.move_ready) begin
                chk("move_expected", 64'(move_q.size() != 0), 1);
                if (move_q.size() != 0) begin
                    move_exp_t m;
                    m = move_q.pop_front();
                    chk("move_src", io.move_src_addr, m.src);
                    chk("move_dst", io.move_dst_addr, m.dst);
                    chk("move_sf", io.move_src_freeze, m.sf);
                    chk("move_df", io.move_dst_freeze, m.df);
                    chk("move_line", io.move_line_num, m.line);
                end
            end
            if (|(io.eu_valid & io.eu_ready)) begin
                chk("eu_expected", 64'(eu_q.size() != 0), 1);
                if (eu_q.size() != 0) begin
                    eu_exp_t u;
                    u = eu_q.pop_front();
                    chk("eu_valid", io.eu_valid, u.vld);
                    chk("eu_exec", io.eu_exec, u.exec);
                    chk("eu_sub_idx", io.eu_sub_idx, u.sub);
                    chk("eu_fetch_addr", io.eu_fetch_addr, u.addr);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge at which the word was pushed.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        io.inst       = w;
        io.inst_valid = 1'b1;
        while (!io.inst_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("send_timeout_inst_ready", io.inst_ready, 1);
        @(posedge clk); #1;
        io.inst_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk_move(input move_exp_t m);
        return {2'b10, m.src, m.dst, m.sf, m.df, m.line};
    endfunction

    move_exp_t mv_tab[5] = '{
        '{10'h3FF, 10'h001, 1'b1, 1'b0, 8'h10},
        '{10'h155, 10'h2AA, 1'b0, 1'b1, 8'h21},
        '{10'h000, 10'h3FF, 1'b1, 1'b1, 8'hFF},
        '{10'h123, 10'h321, 1'b0, 1'b0, 8'h00},
        '{10'h200, 10'h0C0, 1'b1, 1'b0, 8'h7E}
    };

    initial begin
        int n;
        int dwell;
        rst           = 1'b1;
        io.inst_valid = 1'b0;
        io.inst       = '0;
        io.ldst_ready = 1'b1;
        io.move_ready = 1'b0;
        io.eu_ready   = '1;
        io.ldst_busy  = 1'b0;
        io.move_busy  = 1'b0;
        io.eu_busy    = '0;
        cycles(3);
        rst = 1'b0;

        chk("rst_inst_ready", io.inst_ready, 1);
        chk("rst_ldst_valid", io.ldst_valid, 0);
        chk("rst_move_valid", io.move_valid, 0);
        chk("rst_eu_valid", io.eu_valid, 0);
        chk("rst_sync_active", io.sync_active, 0);
        chk("rst_err_illegal", io.err_illegal, 0);
        chk("rst_issued_cnt", io.issued_cnt, 0);

        // LOAD: slot loads one edge after the push, handshake on the following edge.
        ldst_q.push_back('{1'b0, 10'd9, 32'h2000_0340, 8'd4});
        send(32'h0120_3404);
        chk("load_lat_n0", io.ldst_valid, 0);
        cycles(1);
        chk("load_lat_n1", io.ldst_valid, 1);
        cycles(1);
        chk("load_one_cycle", io.ldst_valid, 0);
        chk("load_cnt", io.issued_cnt, 1);

        // MOVEs with mover stalled: slot + 4 FIFO entries fill the unit.
        for (int i = 0; i < 5; i++) begin
            move_q.push_back(mv_tab[i]);
            send(mk_move(mv_tab[i]));
        end
        chk("move_full_inst_ready", io.inst_ready, 0);
        cycles(10);
        chk("move_held_valid", io.move_valid, 1);
        chk("move_held_inst_ready", io.inst_ready, 0);
        io.move_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("move_b2b_valid", io.move_valid, 1);
            cycles(1);
        end
        chk("move_drained", io.move_valid, 0);
        chk("move_inst_ready", io.inst_ready, 1);
        chk("move_cnt", io.issued_cnt, 6);

        // FETCH then EXEC to group 3.
        eu_q.push_back('{8'h08, 1'b0, 4'hA, 32'h0ABC_DEF0});
        eu_q.push_back('{8'h08, 1'b1, 4'h1, 32'h0123_4560});
        send({2'b11, 1'b0, 5'd3, 24'hABCDEF});
        send({2'b11, 1'b1, 5'd3, 24'h123456});
        cycles(4);
        chk("eu_idle", io.eu_valid, 0);
        chk("eu_cnt", io.issued_cnt, 8);

        // SYNC barrier held by a busy EU group, STORE queued behind it.
        io.eu_busy = 8'h04;
        ldst_q.push_back('{1'b1, 10'h1AB, 32'h2000_7770, 8'h55});
        send({2'b11, 1'b1, 5'h1F, 24'h000000});
        send({2'b01, 9'h1AB, 13'h0777, 8'h55});
        n = 0;
        while (!io.sync_active && n < 20) begin
            cycles(1);
            n++;
        end
        chk("sync_seen", io.sync_active, 1);
        dwell = 0;
        for (int i = 0; i < 5; i++) begin
            if (io.sync_active && !io.ldst_valid) dwell++;
            cycles(1);
        end
        chk("sync_dwell", dwell, 5);
        chk("sync_cnt_hold", io.issued_cnt, 8);
        io.eu_busy = 8'h00;
        cycles(4);
        chk("sync_released", io.sync_active, 0);
        chk("sync_store_cnt", io.issued_cnt, 10);

        // Illegal groups are dropped; the following FETCH still dispatches.
        eu_q.push_back('{8'h02, 1'b0, 4'h0, 32'h0000_0100});
        send({2'b11, 1'b0, 5'd12, 24'h000000});
        send({2'b11, 1'b0, 5'h1F, 24'h000000});
        send({2'b11, 1'b0, 5'd1, 24'h000010});
        cycles(4);
        chk("illegal_err", io.err_illegal, 1);
        chk("illegal_cnt", io.issued_cnt, 11);
        cycles(3);
        chk("illegal_sticky", io.err_illegal, 1);

        // Reset with a MOVE presented and three more queued.
        io.move_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk_move(mv_tab[i]));
        chk("pre_rst_move_valid", io.move_valid, 1);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_move_valid", io.move_valid, 0);
        chk("mid_rst_ldst_valid", io.ldst_valid, 0);
        chk("mid_rst_eu_valid", io.eu_valid, 0);
        chk("mid_rst_inst_ready", io.inst_ready, 1);
        chk("mid_rst_cnt", io.issued_cnt, 0);
        chk("mid_rst_err", io.err_illegal, 0);
        rst = 1'b0;
        io.move_ready = 1'b1;
        cycles(10);
        chk("post_rst_no_stale", io.move_valid, 0);
        chk("post_rst_cnt", io.issued_cnt, 0);

        ldst_q.push_back('{1'b0, 10'h1FF, 32'h2001_FFF0, 8'hAA});
        send({2'b00, 9'h1FF, 13'h1FFF, 8'hAA});
        cycles(4);
        chk("post_rst_load_cnt", io.issued_cnt, 1);

        chk("ldst_q_drained", ldst_q.size(), 0);
        chk("move_q_drained", move_q.size(), 0);
        chk("eu_q_drained", eu_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
